alarm_controller: RTL and testbench
===================================

# alarm_controller

Downstream consumer of the system time counter's BCD digit outputs. Holds a user-programmed alarm time, detects when the running time reaches it, and drives the buzzer through a ring / snooze / stop state machine. It runs on the fast system clock, with a one-cycle `sec_tick` strobe marking each 1 Hz count, and its outputs go directly to the buzzer pin and status LEDs.

## Interface
- `RING_SECONDS`, 60: seconds the alarm rings before it shuts off by itself.
- `SNOOZE_SECONDS`, 300: seconds spent in snooze before ringing resumes.
- `clk` in 1: system clock; the only clock.
- `reset` in 1: asynchronous, active-high reset.
- `sec_tick` in 1: one-`clk`-cycle pulse per counted second.
- `sec_units`, `min_units`, `hour_units` in 4 each: BCD units digits of the current time.
- `sec_tens`, `min_tens`, `hour_tens` in 3 each: BCD tens digits of the current time.
- `alarm_minutes` in 6: binary alarm minutes, 0–59.
- `alarm_hours` in 5: binary alarm hours, 0–23.
- `alarm_load` in 1: level input; captures `alarm_minutes`/`alarm_hours` on each cycle it is high.
- `alarm_enable` in 1: arm switch (level).
- `snooze`, `stop` in 1 each: debounced button levels; acted on at their rising edge.
- `stored_minutes` out 6 and `stored_hours` out 5: stored alarm time, for display.
- `ringing` out 1: state is RINGING.
- `snoozing` out 1: state is SNOOZING.
- `buzzer` out 1: buzzer drive, gated on/off once per second.

## Operation
- Alarm registers:
  - On `alarm_load`, out-of-range values (minutes > 59 or hours > 23) are ignored and the old value is kept.
  - Loading never changes the FSM state.
- Current time conversion: minutes = `min_tens`·10 + `min_units`; hours = `hour_tens`·10 + `hour_units`.
- Match condition: hours and minutes equal the stored alarm time, and `sec_tens` = 0 and `sec_units` = 0. Comparison is done at 6-bit width.
- `match_d` holds the registered match. Trigger = match & !`match_d` & `alarm_enable` & state IDLE.
- States:
  - IDLE → RINGING on trigger. This clears `ring_cnt` and sets `buzz_phase` = 1.
  - RINGING:
    - Each `sec_tick` increments `ring_cnt` and toggles `buzz_phase`.
    - Exits to IDLE on a `stop` edge, on `alarm_enable` low, or on the edge that samples the `RING_SECONDS`-th tick.
    - Exits to SNOOZING on a `snooze` edge, loading `snz_cnt` = `SNOOZE_SECONDS`.
  - SNOOZING:
    - Each `sec_tick` decrements `snz_cnt`.
    - When `snz_cnt` goes 1 → 0, moves to RINGING (`ring_cnt` cleared, `buzz_phase` = 1).
    - Exits to IDLE on a `stop` edge or on `alarm_enable` low.
    - A `snooze` edge here is ignored.
- Priority within one cycle, highest first: `alarm_enable` low, `stop`, `snooze`, tick / timeout.
- Any match occurring in RINGING or SNOOZING is ignored.
- `buzzer` = `ringing` & `buzz_phase`, registered.
- Counter widths are `$clog2(param+1)`. Neither counter wraps; each saturates at its limit.

## Timing
- Reset values:
  - All outputs 0.
  - Stored time 00:00.
  - State IDLE, `ring_cnt` = 0, `snz_cnt` = 0.
  - Button edge registers 0.
  - `match_d` = 1, so a current time of 00:00:00 right after reset does not fire the alarm.
- Trigger latency: `ringing` and `buzzer` rise on the first `clk` edge after the cycle in which the trigger condition holds.
- Button latency: the rising edge is detected from a registered previous level. The state changes on the edge after the cycle in which the button first reads 1. A held button acts only once.
- A `sec_tick` coincident with entry into RINGING or SNOOZING is not counted.
- Ring duration: exactly `RING_SECONDS` ticks in RINGING. `buzzer` is high on odd-numbered seconds (1st, 3rd, ...).
- Reset asserted mid-ring or mid-snooze: all outputs go to 0 immediately (asynchronous).
- Loading an alarm time that equals the current time during second 00 fires the alarm one cycle later, through a rising match.

## Test plan
- Basic fire: store 07:30, enabled, drive time to 07:29:59 then 07:30:00 → `ringing`=1 one cycle later. Over `RING_SECONDS`=60 ticks, `buzzer` toggles every tick; back to IDLE after the 60th tick.
- Stop: fire, then pulse `stop` after 3 ticks → IDLE next cycle, `buzzer`=0. Holding `stop` high for 100 cycles causes no further effect.
- Snooze: fire, press `snooze` → `snoozing`=1. After 300 ticks → `ringing`=1, `buzzer`=1. A second `snooze` press during SNOOZING is ignored.
- Simultaneous `stop` + `snooze`, and `alarm_enable` dropped while SNOOZING → IDLE in both cases.
- Load and range check: load 61 min → stored value unchanged. Load 23:59 → `stored_hours`=23, `stored_minutes`=59. Time 23:59:00 fires the alarm. Reset mid-ring → all outputs 0, stored 00:00, no fire with time at 00:00:00.

Source files
------------

// File: rtl/alarm_controller_if.sv
// alarm_controller_if: time digits, alarm programming, buttons and buzzer/status outputs
interface alarm_controller_if;
   logic       sec_tick;
   logic [3:0] sec_units, min_units, hour_units;
   logic [2:0] sec_tens, min_tens, hour_tens;
   logic [5:0] alarm_minutes;
   logic [4:0] alarm_hours;
   logic       alarm_load, alarm_enable, snooze, stop;
   logic [5:0] stored_minutes;
   logic [4:0] stored_hours;
   logic       ringing, snoozing, buzzer;
   modport master (
      output sec_tick, sec_units, min_units, hour_units, sec_tens, min_tens, hour_tens,
             alarm_minutes, alarm_hours, alarm_load, alarm_enable, snooze, stop,
      input  stored_minutes, stored_hours, ringing, snoozing, buzzer
   );
   modport slave (
      input  sec_tick, sec_units, min_units, hour_units, sec_tens, min_tens, hour_tens,
             alarm_minutes, alarm_hours, alarm_load, alarm_enable, snooze, stop,
      output stored_minutes, stored_hours, ringing, snoozing, buzzer
   );
endinterface

// File: rtl/alarm_controller.sv
// alarm_controller: alarm time store, match detect and ring/snooze/stop buzzer FSM
module alarm_controller #(
   parameter int RING_SECONDS   = 60,
   parameter int SNOOZE_SECONDS = 300
) (
   input logic clk,
   input logic reset,
   alarm_controller_if.slave bus
);
   localparam int RW = $clog2(RING_SECONDS + 1);
   localparam int SW = $clog2(SNOOZE_SECONDS + 1);
   typedef enum logic [1:0] {IDLE, RINGING, SNOOZING} state_t;
   state_t        state_q, state_d;
   logic [RW-1:0] ring_cnt_q, ring_cnt_d;
   logic [SW-1:0] snz_cnt_q, snz_cnt_d;
   logic [5:0]    min_q, min_d;
   logic [4:0]    hour_q, hour_d;
   logic          buzz_phase_q, buzz_phase_d, buzzer_q, buzzer_d;
   logic          match_q, match_d, snooze_q, stop_q;
   logic [5:0]    cur_min, cur_hour;
   logic          snooze_edge, stop_edge, en;
   assign en          = bus.alarm_enable;
   assign snooze_edge = bus.snooze & ~snooze_q;
   assign stop_edge   = bus.stop & ~stop_q;
   assign cur_min     = {3'b0, bus.min_tens} * 6'd10 + {2'b0, bus.min_units};
   assign cur_hour    = {3'b0, bus.hour_tens} * 6'd10 + {2'b0, bus.hour_units};
   always_comb begin
      match_d = cur_min == min_q && cur_hour == {1'b0, hour_q} && bus.sec_tens == 3'd0 && bus.sec_units == 4'd0;
      min_d   = (bus.alarm_load && bus.alarm_minutes <= 6'd59) ? bus.alarm_minutes : min_q;
      hour_d  = (bus.alarm_load && bus.alarm_hours <= 5'd23) ? bus.alarm_hours : hour_q;
   end
   always_comb begin
      state_d      = state_q;
      ring_cnt_d   = ring_cnt_q;
      snz_cnt_d    = snz_cnt_q;
      buzz_phase_d = buzz_phase_q;
      case (state_q)
         IDLE: if (match_d && !match_q && en) begin
            state_d      = RINGING;
            ring_cnt_d   = '0;
            buzz_phase_d = 1'b1;
         end
         RINGING: if (!en || stop_edge) state_d = IDLE;
         else if (snooze_edge) begin
            state_d   = SNOOZING;
            snz_cnt_d = SW'(SNOOZE_SECONDS);
         end else if (bus.sec_tick) begin
            ring_cnt_d   = (ring_cnt_q == RW'(RING_SECONDS)) ? ring_cnt_q : ring_cnt_q + RW'(1);
            buzz_phase_d = ~buzz_phase_q;
            state_d      = (ring_cnt_q >= RW'(RING_SECONDS - 1)) ? IDLE : RINGING;
         end
         SNOOZING: if (!en || stop_edge) state_d = IDLE;
         else if (bus.sec_tick) begin
            snz_cnt_d = (snz_cnt_q == '0) ? snz_cnt_q : snz_cnt_q - SW'(1);
            if (snz_cnt_q == SW'(1)) begin
               state_d      = RINGING;
               ring_cnt_d   = '0;
               buzz_phase_d = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
      buzzer_d = state_d == RINGING && buzz_phase_d;
   end
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= IDLE;
         ring_cnt_q   <= '0;
         snz_cnt_q    <= '0;
         min_q        <= '0;
         hour_q       <= '0;
         buzz_phase_q <= 1'b0;
         buzzer_q     <= 1'b0;
         match_q      <= 1'b1;
         snooze_q     <= 1'b0;
         stop_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         ring_cnt_q   <= ring_cnt_d;
         snz_cnt_q    <= snz_cnt_d;
         min_q        <= min_d;
         hour_q       <= hour_d;
         buzz_phase_q <= buzz_phase_d;
         buzzer_q     <= buzzer_d;
         match_q      <= match_d;
         snooze_q     <= bus.snooze;
         stop_q       <= bus.stop;
      end
   end
   assign bus.stored_minutes = min_q;
   assign bus.stored_hours   = hour_q;
   assign bus.ringing        = state_q == RINGING;
   assign bus.snoozing       = state_q == SNOOZING;
   assign bus.buzzer         = buzzer_q;
endmodule

// File: tb/tb_alarm_controller.sv
// tb_alarm_controller: directed vector table plus ring/stop/snooze/reset sequences
module tb_alarm_controller;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_chk = 0;
   int   n_fail = 0;
   alarm_controller_if bus();
   alarm_controller #(.RING_SECONDS(60), .SNOOZE_SECONDS(300)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   typedef struct {
      logic [4:0] lh;
      logic [5:0] lm;
      int         th, tm, ts;
      logic       en;
      logic [4:0] eh;
      logic [5:0] em;
      logic       er;
   } vec_t;
   vec_t vecs[9];
   task automatic step(int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask
   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   task automatic set_time(int h, int m, int s);
      bus.hour_tens  = 3'(h / 10);
      bus.hour_units = 4'(h % 10);
      bus.min_tens   = 3'(m / 10);
      bus.min_units  = 4'(m % 10);
      bus.sec_tens   = 3'(s / 10);
      bus.sec_units  = 4'(s % 10);
   endtask
   task automatic tick();
      bus.sec_tick = 1'b1;
      step();
      bus.sec_tick = 1'b0;
      step();
   endtask
   task automatic fire(int h, int m);
      set_time(h, m, 59);
      step();
      set_time(h, m, 0);
      step();
   endtask
   task automatic load(logic [4:0] h, logic [5:0] m);
      bus.alarm_hours   = h;
      bus.alarm_minutes = m;
      bus.alarm_load    = 1'b1;
      step();
      bus.alarm_load    = 1'b0;
   endtask
   initial begin
      vecs[0] = '{5'd7,  6'd30, 7,  30, 0, 1'b1, 5'd7,  6'd30, 1'b1};
      vecs[1] = '{5'd7,  6'd30, 7,  29, 0, 1'b1, 5'd7,  6'd30, 1'b0};
      vecs[2] = '{5'd7,  6'd61, 7,  30, 0, 1'b1, 5'd7,  6'd30, 1'b1};
      vecs[3] = '{5'd23, 6'd59, 23, 59, 0, 1'b1, 5'd23, 6'd59, 1'b1};
      vecs[4] = '{5'd23, 6'd59, 23, 59, 1, 1'b1, 5'd23, 6'd59, 1'b0};
      vecs[5] = '{5'd24, 6'd59, 23, 59, 0, 1'b1, 5'd23, 6'd59, 1'b1};
      vecs[6] = '{5'd0,  6'd0,  0,  0,  0, 1'b1, 5'd0,  6'd0,  1'b1};
      vecs[7] = '{5'd10, 6'd5,  10, 5,  0, 1'b0, 5'd10, 6'd5,  1'b0};
      vecs[8] = '{5'd12, 6'd0,  2,  0,  0, 1'b1, 5'd12, 6'd0,  1'b0};
      bus.sec_tick = 0; bus.alarm_load = 0; bus.alarm_enable = 0; bus.snooze = 0; bus.stop = 0;
      bus.alarm_hours = 0; bus.alarm_minutes = 0;
      set_time(0, 0, 0);
      step(2);
      chk("rst_ringing", bus.ringing, 0);
      chk("rst_snoozing", bus.snoozing, 0);
      chk("rst_buzzer", bus.buzzer, 0);
      chk("rst_stored", {bus.stored_hours, bus.stored_minutes}, 0);
      reset = 1'b0;
      bus.alarm_enable = 1'b1;
      step(3);
      chk("no_fire_after_rst", bus.ringing, 0);
      foreach (vecs[i]) begin
         bus.alarm_enable = vecs[i].en;
         set_time(12, 34, 56);
         load(vecs[i].lh, vecs[i].lm);
         chk($sformatf("vec%0d_hours", i), bus.stored_hours, vecs[i].eh);
         chk($sformatf("vec%0d_minutes", i), bus.stored_minutes, vecs[i].em);
         set_time(vecs[i].th, vecs[i].tm, vecs[i].ts);
         step();
         chk($sformatf("vec%0d_ringing", i), bus.ringing, vecs[i].er);
         chk($sformatf("vec%0d_buzzer", i), bus.buzzer, vecs[i].er);
         bus.alarm_enable = 1'b0;
         step();
         chk($sformatf("vec%0d_idle", i), bus.ringing, 0);
      end
      bus.alarm_enable = 1'b1;
      load(5'd7, 6'd30);
      fire(7, 30);
      chk("fire_ringing", bus.ringing, 1);
      chk("fire_buzzer", bus.buzzer, 1);
      for (int k = 1; k <= 60; k++) begin
         tick();
         chk($sformatf("ring_t%0d_ringing", k), bus.ringing, k < 60);
         chk($sformatf("ring_t%0d_buzzer", k), bus.buzzer, k < 60 && k % 2 == 0);
      end
      step(3);
      chk("no_refire", bus.ringing, 0);
      fire(7, 30);
      repeat (3) tick();
      chk("stop_pre_buzzer", bus.buzzer, 0);
      bus.stop = 1'b1;
      step();
      chk("stop_ringing", bus.ringing, 0);
      chk("stop_buzzer", bus.buzzer, 0);
      step(100);
      chk("stop_held_idle", bus.ringing, 0);
      fire(7, 30);
      chk("stop_held_refire", bus.ringing, 1);
      bus.stop = 1'b0;
      bus.alarm_enable = 1'b0;
      step();
      chk("enable_low_ring", bus.ringing, 0);
      bus.alarm_enable = 1'b1;
      fire(7, 30);
      bus.snooze = 1'b1;
      step();
      chk("snooze_snoozing", bus.snoozing, 1);
      chk("snooze_ringing", bus.ringing, 0);
      chk("snooze_buzzer", bus.buzzer, 0);
      bus.snooze = 1'b0;
      step();
      bus.snooze = 1'b1;
      step();
      chk("snooze_again", bus.snoozing, 1);
      bus.snooze = 1'b0;
      for (int k = 1; k <= 300; k++) begin
         tick();
         if (k == 299) chk("snz_299", bus.snoozing, 1);
      end
      chk("snz_done_ringing", bus.ringing, 1);
      chk("snz_done_buzzer", bus.buzzer, 1);
      chk("snz_done_snoozing", bus.snoozing, 0);
      bus.stop = 1'b1;
      bus.snooze = 1'b1;
      step();
      chk("both_ringing", bus.ringing, 0);
      chk("both_snoozing", bus.snoozing, 0);
      bus.stop = 1'b0;
      bus.snooze = 1'b0;
      step();
      fire(7, 30);
      bus.snooze = 1'b1;
      step();
      chk("en_drop_pre", bus.snoozing, 1);
      bus.snooze = 1'b0;
      bus.alarm_enable = 1'b0;
      step();
      chk("en_drop_snoozing", bus.snoozing, 0);
      chk("en_drop_ringing", bus.ringing, 0);
      bus.alarm_enable = 1'b1;
      load(5'd23, 6'd59);
      chk("load_2359", {bus.stored_hours, bus.stored_minutes}, {5'd23, 6'd59});
      fire(23, 59);
      chk("fire_2359", bus.ringing, 1);
      #2 reset = 1'b1;
      #1;
      chk("arst_ringing", bus.ringing, 0);
      chk("arst_buzzer", bus.buzzer, 0);
      chk("arst_stored", {bus.stored_hours, bus.stored_minutes}, 0);
      set_time(0, 0, 0);
      step(2);
      reset = 1'b0;
      step(3);
      chk("arst_no_fire", bus.ringing, 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
